// File: rtl/jt10_adpcm_sched.sv
// jt10_adpcm_sched
// Channel scheduler and key-on/off controller for the six-channel ADPCM-A path.
// Produces the time-division strobes shared by the decoder and the accumulator
// and keeps per-channel active / restart / end-flag state.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   cen          sample-rate clock enable; all scheduling state moves on cen
//   kon, koff    one-clk key-on / key-off masks, captured on any clk
//   mute         level mask; muted channels never contribute to the sum
//   dec_end      decoder reached end address for the channel in the cur_ch slot
//   flag_clr     one-clk mask clearing end flags
//   cur_ch       one-hot decoder slot, rotates every cen
//   en_ch        one-hot accumulator phase, rotates once per cur_ch period
//   match        accumulator input carries the sample of the en_ch channel
//   en_sum       that sample should be added (channel active and not muted)
//   active       channel playing
//   restart      per-channel restart request, consumed in the channel's slot
//   flags        end-of-sample flags
module jt10_adpcm_sched #(
  parameter int PIPE_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [5:0] kon,
  input  logic [5:0] koff,
  input  logic [5:0] mute,
  input  logic       dec_end,
  input  logic [5:0] flag_clr,
  output logic [5:0] cur_ch,
  output logic [5:0] en_ch,
  output logic       match,
  output logic       en_sum,
  output logic [5:0] active,
  output logic [5:0] restart,
  output logic [5:0] flags
);

  logic [5:0] cur_ch_r;
  logic [5:0] en_ch_r;
  logic       match_r;
  logic       en_sum_r;
  logic [5:0] active_r;
  logic [5:0] restart_r;
  logic [5:0] flags_r;
  logic [5:0] pend_kon_r;
  logic [5:0] pend_koff_r;
  logic [5:0] dly_ch_s;

  logic [5:0] kon_eff_s;
  logic [5:0] slot_s;
  logic [5:0] end_hit_s;
  logic [5:0] active_nxt_s;
  logic [5:0] restart_nxt_s;
  logic [5:0] flags_nxt_s;

  assign cur_ch  = cur_ch_r;
  assign en_ch   = en_ch_r;
  assign match   = match_r;
  assign en_sum  = en_sum_r;
  assign active  = active_r;
  assign restart = restart_r;
  assign flags   = flags_r;

  // Delay line modelling the decoder latency from cur_ch slot to accumulator input
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign dly_ch_s = cur_ch_r;
    end else begin : g_dly
      logic [5:0] dly_line_r [0:PIPE_DLY-1];

      // Shift the slot one-hot down the line on every cen; empty (zero) after reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) dly_line_r[i] <= 6'b000000;
        end else if (cen) begin
          dly_line_r[0] <= cur_ch_r;
          for (int i = 1; i < PIPE_DLY; i++) dly_line_r[i] <= dly_line_r[i-1];
        end else begin
          for (int i = 0; i < PIPE_DLY; i++) dly_line_r[i] <= dly_line_r[i];
        end
      end

      assign dly_ch_s = dly_line_r[PIPE_DLY-1];
    end
  endgenerate

  // Next-state for channel state applied on cen; koff overrides kon, kon overrides dec_end
  always_comb begin
    kon_eff_s = pend_kon_r & ~pend_koff_r;
    slot_s    = cur_ch_r & active_r;
    if (dec_end) begin
      end_hit_s = slot_s;
    end else begin
      end_hit_s = 6'b000000;
    end
    active_nxt_s  = ((active_r & ~end_hit_s) | kon_eff_s) & ~pend_koff_r;
    restart_nxt_s = ((restart_r & ~slot_s) | kon_eff_s) & ~pend_koff_r;
    // flag_clr acts on any clk; a same-cycle end-of-sample set still wins
    if (cen) begin
      flags_nxt_s = (flags_r & ~flag_clr & ~kon_eff_s) | (end_hit_s & ~kon_eff_s);
    end else begin
      flags_nxt_s = flags_r & ~flag_clr;
    end
  end

  // Pending key masks: fresh pulses on the applying cen stay pending for the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_kon_r  <= 6'b000000;
      pend_koff_r <= 6'b000000;
    end else if (cen) begin
      pend_kon_r  <= kon;
      pend_koff_r <= koff;
    end else begin
      pend_kon_r  <= pend_kon_r | kon;
      pend_koff_r <= pend_koff_r | koff;
    end
  end

  // Flags update on every clk so that flag_clr is not cen-qualified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 6'b000000;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  // Slot/phase rotation, match/en_sum strobes and channel state, all on cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_r  <= 6'b000001;
      en_ch_r   <= 6'b000001;
      match_r   <= 1'b0;
      en_sum_r  <= 1'b0;
      active_r  <= 6'b000000;
      restart_r <= 6'b000000;
    end else if (cen) begin
      cur_ch_r <= {cur_ch_r[4:0], cur_ch_r[5]};
      // Phase advances together with the slot wrapping back to channel 0
      if (cur_ch_r == 6'b100000) begin
        en_ch_r <= {en_ch_r[4:0], en_ch_r[5]};
      end else begin
        en_ch_r <= en_ch_r;
      end
      match_r   <= |(dly_ch_s & en_ch_r);
      en_sum_r  <= |(dly_ch_s & en_ch_r & active_r & ~mute);
      active_r  <= active_nxt_s;
      restart_r <= restart_nxt_s;
    end else begin
      cur_ch_r  <= cur_ch_r;
      en_ch_r   <= en_ch_r;
      match_r   <= match_r;
      en_sum_r  <= en_sum_r;
      active_r  <= active_r;
      restart_r <= restart_r;
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_sched.sv
// Directed bench for jt10_adpcm_sched. A main instance uses PIPE_DLY=2; two
// extra instances (PIPE_DLY=0 and 5) share the inputs so match alignment can be
// checked for the other latencies in the same run.
module tb_jt10_adpcm_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic [5:0] kon = 6'b000000;
  logic [5:0] koff = 6'b000000;
  logic [5:0] mute = 6'b000000;
  logic       dec_end = 1'b0;
  logic [5:0] flag_clr = 6'b000000;

  logic [5:0] cur_ch, en_ch, active, restart, flags;
  logic       match, en_sum;
  logic [5:0] cur_ch0, en_ch0, active0, restart0, flags0;
  logic       match0, en_sum0;
  logic [5:0] cur_ch5, en_ch5, active5, restart5, flags5;
  logic       match5, en_sum5;

  int checks = 0;
  int errors = 0;

  jt10_adpcm_sched #(.PIPE_DLY(2)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .kon(kon), .koff(koff), .mute(mute),
    .dec_end(dec_end), .flag_clr(flag_clr), .cur_ch(cur_ch), .en_ch(en_ch),
    .match(match), .en_sum(en_sum), .active(active), .restart(restart), .flags(flags));

  jt10_adpcm_sched #(.PIPE_DLY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .kon(kon), .koff(koff), .mute(mute),
    .dec_end(dec_end), .flag_clr(flag_clr), .cur_ch(cur_ch0), .en_ch(en_ch0),
    .match(match0), .en_sum(en_sum0), .active(active0), .restart(restart0), .flags(flags0));

  jt10_adpcm_sched #(.PIPE_DLY(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .kon(kon), .koff(koff), .mute(mute),
    .dec_end(dec_end), .flag_clr(flag_clr), .cur_ch(cur_ch5), .en_ch(en_ch5),
    .match(match5), .en_sum(en_sum5), .active(active5), .restart(restart5), .flags(flags5));

  always #5 clk = ~clk;

  // Expected slot after n cens from reset
  function automatic logic [5:0] exp_cur(int n);
    logic [5:0] one;
    one = 6'b000001;
    return one << (n % 6);
  endfunction

  // Expected phase after n cens from reset
  function automatic logic [5:0] exp_en(int n);
    logic [5:0] one;
    one = 6'b000001;
    return one << ((n / 6) % 6);
  endfunction

  // match after n cens: delayed slot (d cens old) equals phase at cen n-1
  function automatic logic exp_match(int n, int d);
    if (n - 1 < d) return 1'b0;
    return (((n - 1 - d) % 6) == (((n - 1) / 6) % 6));
  endfunction

  task automatic cen_step();
    cen = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0;
  endtask

  task automatic idle_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_kon(input logic [5:0] m);
    kon = m;
    idle_clk();
    kon = 6'b000000;
  endtask

  task automatic pulse_koff(input logic [5:0] m);
    koff = m;
    idle_clk();
    koff = 6'b000000;
  endtask

  task automatic do_reset();
    cen = 1'b0; kon = 6'b000000; koff = 6'b000000; mute = 6'b000000;
    dec_end = 1'b0; flag_clr = 6'b000000;
    rst_n = 1'b0;
    idle_clk();
    rst_n = 1'b1;
    idle_clk();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_clk();
    checks++;
    if ({cur_ch, en_ch, match, en_sum, active, restart, flags} !==
        {6'b000001, 6'b000001, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000}) begin
      errors++;
      $display("FAIL reset_state got cur=%b en=%b m=%b s=%b act=%b rst=%b fl=%b", cur_ch, en_ch,
               match, en_sum, active, restart, flags);
    end
    checks++;
    if ({cur_ch0, cur_ch5, match0, match5} !== {6'b000001, 6'b000001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_alt got cur0=%b cur5=%b m0=%b m5=%b", cur_ch0, cur_ch5, match0, match5);
    end
    rst_n = 1'b1;
    idle_clk();
  endtask

  task automatic test_rotation_match();
    int cnt2, cnt0, cnt5;
    cnt2 = 0; cnt0 = 0; cnt5 = 0;
    do_reset();
    for (int n = 1; n <= 42; n++) begin
      cen_step();
      checks++;
      if (cur_ch !== exp_cur(n)) begin
        errors++;
        $display("FAIL rot_cur n=%0d got %b exp %b", n, cur_ch, exp_cur(n));
      end
      checks++;
      if (en_ch !== exp_en(n)) begin
        errors++;
        $display("FAIL rot_en n=%0d got %b exp %b", n, en_ch, exp_en(n));
      end
      checks++;
      if (match !== exp_match(n, 2)) begin
        errors++;
        $display("FAIL match_d2 n=%0d got %b exp %b", n, match, exp_match(n, 2));
      end
      checks++;
      if (match0 !== exp_match(n, 0)) begin
        errors++;
        $display("FAIL match_d0 n=%0d got %b exp %b", n, match0, exp_match(n, 0));
      end
      checks++;
      if (match5 !== exp_match(n, 5)) begin
        errors++;
        $display("FAIL match_d5 n=%0d got %b exp %b", n, match5, exp_match(n, 5));
      end
      if (n >= 3 && n <= 38 && match === 1'b1) cnt2++;
      if (n >= 1 && n <= 36 && match0 === 1'b1) cnt0++;
      if (n >= 6 && n <= 41 && match5 === 1'b1) cnt5++;
    end
    checks++;
    if (cnt2 != 6 || cnt0 != 6 || cnt5 != 6) begin
      errors++;
      $display("FAIL match_count got d2=%0d d0=%0d d5=%0d exp 6 each", cnt2, cnt0, cnt5);
    end
  endtask

  task automatic test_kon();
    int cnt_a, cnt_b;
    logic exp_s;
    int p;
    cnt_a = 0; cnt_b = 0;
    do_reset();
    pulse_kon(6'b000101);
    for (int n = 1; n <= 72; n++) begin
      if (n == 37) mute = 6'b000100;
      cen_step();
      if (n == 1 || n == 3 || n == 6 || n == 7) begin
        checks++;
        if (restart !== ((n < 3) ? 6'b000101 : (n < 7) ? 6'b000001 : 6'b000000)) begin
          errors++;
          $display("FAIL kon_restart n=%0d got %b", n, restart);
        end
      end
      if (n == 1) begin
        checks++;
        if (active !== 6'b000101) begin
          errors++;
          $display("FAIL kon_active got %b exp 000101", active);
        end
      end
      p = ((n - 1) / 6) % 6;
      exp_s = exp_match(n, 2) && ((p == 0) || (p == 2 && n <= 36));
      checks++;
      if (en_sum !== exp_s) begin
        errors++;
        $display("FAIL kon_en_sum n=%0d got %b exp %b", n, en_sum, exp_s);
      end
      if (en_sum === 1'b1) begin
        if (n <= 36) cnt_a++;
        else cnt_b++;
      end
    end
    checks++;
    if (cnt_a != 2 || cnt_b != 1) begin
      errors++;
      $display("FAIL en_sum_count got %0d/%0d exp 2/1", cnt_a, cnt_b);
    end
    mute = 6'b000000;
  endtask

  task automatic test_dec_end();
    do_reset();
    pulse_kon(6'b000101);
    cen_step();
    cen_step();
    dec_end = 1'b1;
    cen_step();
    dec_end = 1'b0;
    checks++;
    if ({active, flags} !== {6'b000001, 6'b000100}) begin
      errors++;
      $display("FAIL dec_end_ch2 got act=%b fl=%b exp 000001/000100", active, flags);
    end
    dec_end = 1'b1;
    cen_step();
    dec_end = 1'b0;
    checks++;
    if ({active, flags} !== {6'b000001, 6'b000100}) begin
      errors++;
      $display("FAIL dec_end_inactive got act=%b fl=%b exp 000001/000100", active, flags);
    end
    flag_clr = 6'b000100;
    idle_clk();
    flag_clr = 6'b000000;
    checks++;
    if ({active, flags} !== {6'b000001, 6'b000000}) begin
      errors++;
      $display("FAIL flag_clr got act=%b fl=%b exp 000001/000000", active, flags);
    end
    cen_step();
    cen_step();
    dec_end = 1'b1;
    flag_clr = 6'b000001;
    cen_step();
    dec_end = 1'b0;
    flag_clr = 6'b000000;
    checks++;
    if ({active, flags} !== {6'b000000, 6'b000001}) begin
      errors++;
      $display("FAIL set_over_clr got act=%b fl=%b exp 000000/000001", active, flags);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    pulse_kon(6'b000010);
    pulse_koff(6'b000010);
    cen_step();
    checks++;
    if ({active, restart} !== {6'b000000, 6'b000000}) begin
      errors++;
      $display("FAIL kon_koff got act=%b rst=%b exp 0/0", active, restart);
    end
    do_reset();
    pulse_kon(6'b010000);
    cen_step();
    checks++;
    if (active !== 6'b010000) begin
      errors++;
      $display("FAIL kon4_active got %b exp 010000", active);
    end
    cen_step();
    cen_step();
    cen_step();
    pulse_kon(6'b010000);
    dec_end = 1'b1;
    cen_step();
    dec_end = 1'b0;
    checks++;
    if ({active, flags} !== {6'b010000, 6'b000000}) begin
      errors++;
      $display("FAIL kon_over_end got act=%b fl=%b exp 010000/000000", active, flags);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    kon = 6'b000001;
    cen_step();
    kon = 6'b000000;
    checks++;
    if (active !== 6'b000000) begin
      errors++;
      $display("FAIL kon_on_cen_early got %b exp 000000", active);
    end
    cen_step();
    checks++;
    if (active !== 6'b000001) begin
      errors++;
      $display("FAIL kon_on_cen_kept got %b exp 000001", active);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_kon(6'b000111);
    cen_step();
    cen_step();
    cen_step();
    pulse_kon(6'b001000);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cur_ch, en_ch, match, en_sum, active, restart, flags} !==
        {6'b000001, 6'b000001, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000}) begin
      errors++;
      $display("FAIL async_reset got cur=%b en=%b act=%b rst=%b fl=%b", cur_ch, en_ch, active,
               restart, flags);
    end
    #1;
    rst_n = 1'b1;
    cen_step();
    checks++;
    if ({cur_ch, en_ch, active} !== {6'b000010, 6'b000001, 6'b000000}) begin
      errors++;
      $display("FAIL post_reset got cur=%b en=%b act=%b exp 000010/000001/000000", cur_ch, en_ch,
               active);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_rotation_match();
    test_kon();
    test_dec_end();
    test_conflict();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
